button_debouncer: RTL and testbench

- Upstream conditioning stage for the board's active-low push-buttons (the go button in front of the counting FSM).
- Synchronises the raw pin to clk and debounces it with a four-state FSM and stability counter.
- Outputs a clean active-high level, one-cycle press/release pulses, and a one-shot long-press pulse.
- Downstream FSMs sample the pulses or level directly, with no further filtering.

---
 rtl/button_debouncer.sv | 144 ++++++++++++++
 tb/tb_button_debouncer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser feeding a debounce FSM
// with stability and hold counters; emits level, edge and long-press pulses.
module button_debouncer #(
  parameter int unsigned          CNT_WIDTH    = 24,
  parameter logic [CNT_WIDTH-1:0] STABLE_COUNT = 24'd120000,
  parameter logic [CNT_WIDTH-1:0] LONG_COUNT   = 24'd12000000
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    RELEASED      = 2'b00,
    PRESS_CHECK   = 2'b01,
    PRESSED       = 2'b11,
    RELEASE_CHECK = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STAB_MAX = STABLE_COUNT - 1'b1;
  localparam logic [CNT_WIDTH-1:0] LONG_MAX = LONG_COUNT - 1'b1;

  logic sync1;
  logic sync2;
  logic pressed;

  state_t               state;
  state_t               state_n;
  logic [CNT_WIDTH-1:0] stab_cnt;
  logic [CNT_WIDTH-1:0] stab_n;
  logic [CNT_WIDTH-1:0] hold_cnt;
  logic [CNT_WIDTH-1:0] hold_n;
  logic                 long_done;
  logic                 done_n;
  logic                 level_n;
  logic                 press_n;
  logic                 rel_n;
  logic                 long_n;

  // Sync flops idle at 1 so a held button looks like a fresh press
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state         <= RELEASED;
      stab_cnt      <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_n;
      stab_cnt      <= stab_n;
      hold_cnt      <= hold_n;
      long_done     <= done_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= rel_n;
      long_press    <= long_n;
    end
  end

  always_comb begin
    state_n = state;
    stab_n  = stab_cnt;
    hold_n  = hold_cnt;
    done_n  = long_done;
    level_n = btn_level;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    unique case (state)
      RELEASED: begin
        stab_n = '0;
        if (pressed) begin
          state_n = PRESS_CHECK;
        end
      end
      PRESS_CHECK: begin
        if (!pressed) begin
          state_n = RELEASED;
          stab_n  = '0;
        end else if (stab_cnt == STAB_MAX) begin
          state_n = PRESSED;
          level_n = 1'b1;
          press_n = 1'b1;
          hold_n  = '0;
        end else begin
          stab_n = stab_cnt + 1'b1;
        end
      end
      PRESSED: begin
        // A release seen on the long-press cycle takes priority
        if (!pressed) begin
          state_n = RELEASE_CHECK;
          stab_n  = '0;
        end else if (hold_cnt == LONG_MAX) begin
          if (!long_done) begin
            long_n = 1'b1;
            done_n = 1'b1;
          end
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      RELEASE_CHECK: begin
        if (pressed) begin
          state_n = PRESSED;
        end else if (stab_cnt == STAB_MAX) begin
          state_n = RELEASED;
          level_n = 1'b0;
          rel_n   = 1'b1;
          done_n  = 1'b0;
        end else begin
          stab_n = stab_cnt + 1'b1;
        end
      end
      default: begin
        state_n = RELEASED;
        stab_n  = '0;
        hold_n  = '0;
        done_n  = 1'b0;
        level_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: a table of per-edge stimulus with expected
// outputs, checked through a scoreboard queue one edge at a time.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst_btn;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    string      tag;
    logic       rst;
    logic       btn;
    int         n;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  button_debouncer #(
    .CNT_WIDTH   (8),
    .STABLE_COUNT(8'd4),
    .LONG_COUNT  (8'd20)
  ) dut (
    .clk          (clk),
    .rst_btn      (rst_btn),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  // exp = {btn_level, press_pulse, release_pulse, long_press}
  function automatic void add(string t, logic r, logic b, int n,
                              logic [3:0] e);
    vec_t v;
    v.tag = t;
    v.rst = r;
    v.btn = b;
    v.n   = n;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic void add_release(string t);
    add(t, 1'b1, 1'b1, 6, 4'b1000);
    add(t, 1'b1, 1'b1, 1, 4'b0010);
    add(t, 1'b1, 1'b1, 2, 4'b0000);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic [3:0] got;
    cyc++;
    #1;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      got = {btn_level, press_pulse, release_pulse, long_press};
      tests++;
      if (got !== e.exp) begin
        fails++;
        $display("FAIL %s cyc %0d: lvl/press/rel/long got %b want %b",
                 e.tag, cyc, got, e.exp);
      end
    end
  end

  initial begin
    exp_t x;
    rst_btn = 1'b0;
    btn_in  = 1'b1;

    for (int i = 0; i < 5; i++)
      add("reset", 1'b0, i[0], 1, 4'b0000);
    add("reset_rel", 1'b1, 1'b1, 3, 4'b0000);

    add("clean", 1'b1, 1'b0, 6, 4'b0000);
    add("clean", 1'b1, 1'b0, 1, 4'b1100);
    add("clean", 1'b1, 1'b0, 8, 4'b1000);
    add_release("clean_rel");

    add("bounce", 1'b1, 1'b0, 3, 4'b0000);
    add("bounce", 1'b1, 1'b1, 1, 4'b0000);
    add("bounce", 1'b1, 1'b0, 2, 4'b0000);
    add("bounce", 1'b1, 1'b1, 6, 4'b0000);
    add("after_bounce", 1'b1, 1'b0, 6, 4'b0000);
    add("after_bounce", 1'b1, 1'b0, 1, 4'b1100);
    add("after_bounce", 1'b1, 1'b0, 3, 4'b1000);
    add_release("after_bounce_rel");

    add("long", 1'b1, 1'b0, 6, 4'b0000);
    add("long", 1'b1, 1'b0, 1, 4'b1100);
    add("long", 1'b1, 1'b0, 19, 4'b1000);
    add("long", 1'b1, 1'b0, 1, 4'b1001);
    add("long", 1'b1, 1'b0, 13, 4'b1000);
    add_release("long_rel");

    add("rel_bounce", 1'b1, 1'b0, 6, 4'b0000);
    add("rel_bounce", 1'b1, 1'b0, 1, 4'b1100);
    add("rel_bounce", 1'b1, 1'b0, 3, 4'b1000);
    add("rel_bounce", 1'b1, 1'b1, 2, 4'b1000);
    add("rel_bounce", 1'b1, 1'b0, 8, 4'b1000);
    add_release("rel_bounce_rel");

    add("rel_vs_long", 1'b1, 1'b0, 6, 4'b0000);
    add("rel_vs_long", 1'b1, 1'b0, 1, 4'b1100);
    add("rel_vs_long", 1'b1, 1'b0, 17, 4'b1000);
    add_release("rel_vs_long_rel");

    add("rst_mid", 1'b1, 1'b0, 4, 4'b0000);
    add("rst_mid", 1'b0, 1'b0, 3, 4'b0000);
    add("rst_mid_after", 1'b1, 1'b0, 6, 4'b0000);
    add("rst_mid_after", 1'b1, 1'b0, 1, 4'b1100);
    add("rst_mid_after", 1'b1, 1'b0, 3, 4'b1000);
    add("rst_pressed", 1'b0, 1'b0, 2, 4'b0000);
    add("rst_pressed", 1'b1, 1'b1, 4, 4'b0000);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        @(negedge clk);
        rst_btn = vecs[i].rst;
        btn_in  = vecs[i].btn;
        x.tag   = vecs[i].tag;
        x.exp   = vecs[i].exp;
        sb.push_back(x);
      end
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
